// File: rtl/wb_pipe.sv
// Write-back stage: selects the result source, extracts and extends load data, and registers the RF write port.
// Latency: 1 cycle from MEM-stage inputs to wb_o/rd_o/we_o/valid_o, with a sustained throughput of 1 instr/cycle.
// Backpressure: stall_i holds every output and the counter; flush_i kills the capture and takes priority over stall_i.
module wb_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic [XLEN-1:0]             pc_4_i,
    input  logic [XLEN-1:0]             alu_i,
    input  logic [XLEN-1:0]             mem_i,
    input  logic [1:0]                  wb_sel_i,
    input  logic [2:0]                  funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   addr_lsb_i,
    input  logic [REG_AW-1:0]           rd_i,
    input  logic                        rd_we_i,
    output logic [XLEN-1:0]             wb_o,
    output logic [REG_AW-1:0]           rd_o,
    output logic                        we_o,
    output logic                        valid_o,
    output logic [CNT_W-1:0]            instret_o
);

    localparam int OFF_W = $clog2(XLEN/8);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    logic [7:0]      byte_raw;
    logic [15:0]     half_raw;
    logic [31:0]     word_raw;
    logic [XLEN-1:0] load_dat;
    logic [XLEN-1:0] sel_dat;
    logic            cap_we;

    // Byte lane picked directly by the byte offset; half lane drops offset bit 0 so misaligned LH reads the enclosing half.
    assign byte_raw = mem_i[{addr_lsb_i, 3'b000} +: 8];
    assign half_raw = mem_i[{addr_lsb_i[OFF_W-1:1], 4'b0000} +: 16];

    // Only a 64-bit datapath has two word lanes; the low offset bits are ignored for word loads.
    generate
        if (XLEN == 64) begin : g_word64
            assign word_raw = mem_i[{addr_lsb_i[OFF_W-1], 5'b00000} +: 32];
        end else begin : g_word32
            assign word_raw = mem_i[31:0];
        end
    endgenerate

    // Load alignment and sign/zero extension; encodings that don't apply to this XLEN pass the raw word through.
    always_comb begin
        load_dat = mem_i;
        case (funct3_i)
            F3_LB:  load_dat = XLEN'($signed(byte_raw));
            F3_LH:  load_dat = XLEN'($signed(half_raw));
            F3_LW:  load_dat = (XLEN == 64) ? XLEN'($signed(word_raw)) : mem_i;
            F3_LD:  load_dat = mem_i;
            F3_LBU: load_dat = XLEN'(byte_raw);
            F3_LHU: load_dat = XLEN'(half_raw);
            F3_LWU: load_dat = (XLEN == 64) ? XLEN'(word_raw) : mem_i;
            default: load_dat = mem_i;
        endcase
    end

    // Result source select; 11 aliases the ALU result.
    always_comb begin
        sel_dat = alu_i;
        case (wb_sel_i)
            SEL_ALU: sel_dat = alu_i;
            SEL_MEM: sel_dat = load_dat;
            SEL_PC4: sel_dat = pc_4_i;
            default: sel_dat = alu_i;
        endcase
    end

    // Writes to x0 never reach the register file, and a bubble never writes.
    assign cap_we = valid_i & rd_we_i & (rd_i != '0);

    // Pipeline register: flush kills the instruction being captured, stall freezes everything, otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_o    <= '0;
            rd_o    <= '0;
            we_o    <= 1'b0;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            we_o    <= 1'b0;
        end else if (!stall_i) begin
            valid_o <= valid_i;
            rd_o    <= rd_i;
            wb_o    <= sel_dat;
            we_o    <= cap_we;
        end
    end

    // Retired-instruction counter: counts live captures only and wraps naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_o <= '0;
        end else if (!flush_i && !stall_i && valid_i) begin
            instret_o <= instret_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: a 32-bit instance (4-bit counter) and a 64-bit instance share one stimulus stream.
// Latency: outputs are compared 1 time unit after each rising edge against a reference model.
// Backpressure: stall and flush are driven both directed and at random.
module tb_wb_pipe;

    logic        clk;
    logic        rst_n;
    logic        valid, stall, flush, rd_we;
    logic [1:0]  sel;
    logic [2:0]  f3, off;
    logic [4:0]  rd;
    logic [63:0] pc4, alu, mem;

    logic [31:0] wb_a;  logic [4:0] rd_a;  logic we_a, vld_a;  logic [3:0]  cnt_a;
    logic [63:0] wb_b;  logic [4:0] rd_b;  logic we_b, vld_b;  logic [31:0] cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, index 0 = 32-bit instance, 1 = 64-bit instance.
    logic [63:0] m_wb[2];
    logic [4:0]  m_rd[2];
    logic        m_we[2];
    logic        m_vld[2];
    logic [63:0] m_cnt[2];

    wb_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .pc_4_i(pc4[31:0]), .alu_i(alu[31:0]), .mem_i(mem[31:0]), .wb_sel_i(sel),
        .funct3_i(f3), .addr_lsb_i(off[1:0]), .rd_i(rd), .rd_we_i(rd_we),
        .wb_o(wb_a), .rd_o(rd_a), .we_o(we_a), .valid_o(vld_a), .instret_o(cnt_a)
    );

    wb_pipe #(.XLEN(64), .REG_AW(5), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .pc_4_i(pc4), .alu_i(alu), .mem_i(mem), .wb_sel_i(sel),
        .funct3_i(f3), .addr_lsb_i(off), .rd_i(rd), .rd_we_i(rd_we),
        .wb_o(wb_b), .rd_o(rd_b), .we_o(we_b), .valid_o(vld_b), .instret_o(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        return v[n-1] ? (v | (~64'd0 << n)) : v;
    endfunction

    // Write-back value from the ISA rules, using shifts and masks on the whole word.
    function automatic logic [63:0] wb_value(input int xl);
        logic [63:0] mask, m, b, h, w, r;
        int bo;
        mask = (xl == 64) ? ~64'd0 : 64'hFFFF_FFFF;
        m    = mem & mask;
        bo   = (xl == 64) ? int'(off) : int'(off) % 4;
        b    = (m >> (bo * 8)) & 64'hFF;
        h    = (m >> ((bo / 2) * 16)) & 64'hFFFF;
        w    = (xl == 64) ? ((m >> ((bo / 4) * 32)) & 64'hFFFF_FFFF) : m;
        if (sel == 2'd1) begin
            case (f3)
                3'd0: r = sext(b, 8);
                3'd1: r = sext(h, 16);
                3'd2: r = (xl == 64) ? sext(w, 32) : m;
                3'd4: r = b;
                3'd5: r = h;
                3'd6: r = (xl == 64) ? w : m;
                default: r = m;
            endcase
        end else if (sel == 2'd2) begin
            r = pc4;
        end else begin
            r = alu;
        end
        return r & mask;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wb[i] = '0; m_rd[i] = '0; m_we[i] = 1'b0; m_vld[i] = 1'b0; m_cnt[i] = '0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            int cw;
            cw = (i == 0) ? 4 : 32;
            if (flush) begin
                m_vld[i] = 1'b0;
                m_we[i]  = 1'b0;
            end else if (!stall) begin
                m_vld[i] = valid;
                m_rd[i]  = rd;
                m_wb[i]  = wb_value((i == 0) ? 32 : 64);
                m_we[i]  = valid && rd_we && (rd != 0);
                if (valid) m_cnt[i] = (m_cnt[i] + 1) % (64'd1 << cw);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".a.wb"},  64'(wb_a),  m_wb[0]);
        check({tag, ".a.rd"},  64'(rd_a),  64'(m_rd[0]));
        check({tag, ".a.we"},  64'(we_a),  64'(m_we[0]));
        check({tag, ".a.vld"}, 64'(vld_a), 64'(m_vld[0]));
        check({tag, ".a.cnt"}, 64'(cnt_a), m_cnt[0]);
        check({tag, ".b.wb"},  wb_b,       m_wb[1]);
        check({tag, ".b.rd"},  64'(rd_b),  64'(m_rd[1]));
        check({tag, ".b.we"},  64'(we_b),  64'(m_we[1]));
        check({tag, ".b.vld"}, 64'(vld_b), 64'(m_vld[1]));
        check({tag, ".b.cnt"}, 64'(cnt_b), m_cnt[1]);
    endtask

    task automatic step(input string tag);
        model_clock();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic load(input logic [2:0] fn, input logic [2:0] o);
        sel = 2'd1; f3 = fn; off = o;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0; stall = 1'b0; flush = 1'b0; rd_we = 1'b0;
        sel = '0; f3 = '0; off = '0; rd = '0; pc4 = '0; alu = '0; mem = '0;
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result path
        valid = 1'b1; rd_we = 1'b1; sel = 2'd0; alu = 64'h1234_5678; rd = 5'd5;
        step("alu");
        check("alu.wb", 64'(wb_a), 64'h1234_5678);
        check("alu.we", 64'(we_a), 64'd1);
        check("alu.cnt", 64'(cnt_a), 64'd1);

        // Load extraction on the 32-bit lanes
        mem = 64'h80FF_7F01;
        load(3'd0, 3'd3); step("lb");  check("lb.off3",  64'(wb_a), 64'hFFFF_FF80);
        load(3'd4, 3'd3); step("lbu"); check("lbu.off3", 64'(wb_a), 64'h0000_0080);
        load(3'd1, 3'd2); step("lh");  check("lh.off2",  64'(wb_a), 64'hFFFF_80FF);
        load(3'd5, 3'd0); step("lhu"); check("lhu.off0", 64'(wb_a), 64'h0000_7F01);
        load(3'd1, 3'd3); step("lh.mis"); check("lh.misaligned", 64'(wb_a), 64'hFFFF_80FF);

        // JAL link, then the same with rd = x0
        sel = 2'd2; pc4 = 64'h104; rd = 5'd1;
        step("jal");   check("jal.wb", 64'(wb_a), 64'h104); check("jal.we", 64'(we_a), 64'd1);
        rd = 5'd0;
        step("jal.x0"); check("jal.x0.we", 64'(we_a), 64'd0); check("jal.x0.vld", 64'(vld_a), 64'd1);

        // Stall for three cycles while the inputs keep changing
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu = {$urandom, $urandom}; sel = 2'd0; rd = 5'(i + 7);
            step("stall");
        end
        check("stall.cnt", 64'(cnt_a), 64'd8);
        check("stall.wb",  64'(wb_a),  64'h104);

        // Flush together with stall kills the stage
        flush = 1'b1;
        step("flush_stall");
        check("flush.vld", 64'(vld_a), 64'd0);
        check("flush.cnt", 64'(cnt_a), 64'd8);
        stall = 1'b0; flush = 1'b0;

        // 64-bit word loads
        mem = 64'h0000_0000_8000_0000; rd = 5'd9;
        load(3'd2, 3'd0); step("lw64");  check("lw64",  wb_b, 64'hFFFF_FFFF_8000_0000);
        load(3'd6, 3'd0); step("lwu64"); check("lwu64", wb_b, 64'h0000_0000_8000_0000);
        mem = 64'h8000_0000_0000_0000;
        load(3'd2, 3'd5); step("lw64.hi"); check("lw64.hi", wb_b, 64'hFFFF_FFFF_8000_0000);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rd_we = ($urandom_range(0, 4) != 0);
            sel   = 2'($urandom);
            f3    = 3'($urandom);
            off   = 3'($urandom);
            rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            pc4   = {$urandom, $urandom};
            alu   = {$urandom, $urandom};
            mem   = {$urandom, $urandom};
            step("rand");
        end

        // Asynchronous reset while stalled clears outputs before the next edge
        stall = 1'b1; flush = 1'b0; valid = 1'b1;
        step("pre_rst");
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        check("async_rst.cnt", 64'(cnt_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seventeen live captures wrap the 4-bit counter back to one
        stall = 1'b0; flush = 1'b0; valid = 1'b1; sel = 2'd0; rd_we = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rd  = 5'($urandom);
            alu = {$urandom, $urandom};
            step("wrap");
        end
        check("wrap.cnt4",  64'(cnt_a), 64'd1);
        check("wrap.cnt32", 64'(cnt_b), 64'd17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
